// File: rtl/oc_watchdog.sv
// Millisecond watchdog on the chip status bus: programmable countdown with a warn
// level, a sticky bite and a saturating lifetime bite counter.

package oclib_pkg;
  typedef struct packed {
    logic tick1us;
    logic tick1ms;
    logic tick1s;
    logic halt;
    logic clear;
    logic error;
  } chip_status_s;
endpackage

module oc_watchdog #(
  parameter int unsigned CounterWidth   = 16,
  parameter int unsigned BiteCountWidth = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  oclib_pkg::chip_status_s   chipStatus,
  input  logic                      enable,
  input  logic                      kick,
  input  logic [CounterWidth-1:0]   cfgTimeoutMs,
  input  logic [CounterWidth-1:0]   cfgWarnMs,
  output logic [CounterWidth-1:0]   remainingMs,
  output logic                      warn,
  output logic                      bite,
  output logic                      bitePulse,
  output logic [BiteCountWidth-1:0] biteCount,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWarn = 2'd2,
    StBite = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [CounterWidth-1:0]   rem_q, rem_d;
  logic [BiteCountWidth-1:0] cnt_q, cnt_d;
  logic                      pulse_q, pulse_d;
  logic                      tick_q, ms_edge_q;
  logic                      tick_strobe;
  logic [CounterWidth-1:0]   reload;
  logic [CounterWidth-1:0]   dec;
  logic                      unused_status;

  assign unused_status = ^{chipStatus.tick1us, chipStatus.tick1s, chipStatus.error};

  assign reload      = (cfgTimeoutMs == '0) ? CounterWidth'(1) : cfgTimeoutMs;
  assign dec         = (rem_q == '0) ? '0 : rem_q - CounterWidth'(1);
  // Tick history keeps tracking through halt so no stale edge fires when halt drops.
  assign tick_strobe = ms_edge_q & ~chipStatus.halt;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (chipStatus.clear || (!enable && !chipStatus.halt)) begin
      state_d = StIdle;
      rem_d   = reload;
    end else if (chipStatus.halt) begin
      if (kick && (state_q == StRun || state_q == StWarn)) begin
        state_d = StRun;
        rem_d   = reload;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StRun;
          rem_d   = reload;
        end
        StRun, StWarn: begin
          if (kick) begin
            state_d = StRun;
            rem_d   = reload;
          end else if (tick_strobe) begin
            rem_d = dec;
            if (dec == '0) begin
              state_d = StBite;
              pulse_d = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + BiteCountWidth'(1);
            end else if (cfgWarnMs != '0 && dec <= cfgWarnMs) begin
              state_d = StWarn;
            end
          end
        end
        StBite: rem_d = '0;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      tick_q    <= 1'b0;
      ms_edge_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      tick_q    <= chipStatus.tick1ms;
      ms_edge_q <= chipStatus.tick1ms & ~tick_q;
    end
  end

  assign remainingMs = rem_q;
  assign warn        = (state_q == StWarn);
  assign bite        = (state_q == StBite);
  assign bitePulse   = pulse_q;
  assign biteCount   = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_oc_watchdog.sv
// Directed bench for oc_watchdog: expiry, kicking, kick/tick collision, clear,
// halt and asynchronous reset.

module tb_oc_watchdog;
  localparam int unsigned TickPeriod = 20;
  localparam int unsigned TickWidth  = 5;

  logic                    clock = 1'b0;
  logic                    reset;
  oclib_pkg::chip_status_s chipStatus;
  logic                    enable;
  logic                    kick;
  logic [15:0]             cfgTimeoutMs;
  logic [15:0]             cfgWarnMs;
  logic [15:0]             remainingMs;
  logic                    warn;
  logic                    bite;
  logic                    bitePulse;
  logic [7:0]              biteCount;
  logic [1:0]              state;

  int checks = 0;
  int errors = 0;

  oc_watchdog #(
    .CounterWidth  (16),
    .BiteCountWidth(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .chipStatus  (chipStatus),
    .enable      (enable),
    .kick        (kick),
    .cfgTimeoutMs(cfgTimeoutMs),
    .cfgWarnMs   (cfgWarnMs),
    .remainingMs (remainingMs),
    .warn        (warn),
    .bite        (bite),
    .bitePulse   (bitePulse),
    .biteCount   (biteCount),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full ms tick period, driven and ended on falling edges.
  task automatic do_tick();
    chipStatus.tick1ms = 1'b1;
    repeat (TickWidth) @(negedge clock);
    chipStatus.tick1ms = 1'b0;
    repeat (TickPeriod - TickWidth) @(negedge clock);
  endtask

  initial begin
    chipStatus   = '0;
    enable       = 1'b1;
    kick         = 1'b0;
    cfgTimeoutMs = 16'd5;
    cfgWarnMs    = 16'd2;
    reset        = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", 32'(state), 0);
    check("reset_rem", 32'(remainingMs), 0);
    check("reset_outs", 32'({warn, bite, bitePulse}), 0);
    check("reset_cnt", 32'(biteCount), 0);

    // Expiry without kicks
    reset = 1'b1;
    @(negedge clock);
    check("arm_state", 32'(state), 1);
    check("arm_rem", 32'(remainingMs), 5);
    do_tick();
    check("t1_rem", 32'(remainingMs), 4);
    do_tick();
    check("t2_rem", 32'(remainingMs), 3);
    check("t2_warn", 32'(warn), 0);
    do_tick();
    check("t3_rem", 32'(remainingMs), 2);
    check("t3_warn", 32'(warn), 1);
    do_tick();
    check("t4_rem", 32'(remainingMs), 1);
    chipStatus.tick1ms = 1'b1;
    @(negedge clock);
    check("t5_pre_bite", 32'(bite), 0);
    @(negedge clock);
    check("t5_rem", 32'(remainingMs), 0);
    check("t5_bite", 32'({bite, bitePulse, warn}), 3'b110);
    check("t5_cnt", 32'(biteCount), 1);
    @(negedge clock);
    check("t5_pulse_end", 32'({bite, bitePulse}), 2'b10);
    repeat (TickWidth - 2) @(negedge clock);
    chipStatus.tick1ms = 1'b0;
    repeat (TickPeriod - TickWidth) @(negedge clock);

    // Kick is ignored in bite; clear returns to idle keeping the count
    kick = 1'b1;
    @(negedge clock);
    kick = 1'b0;
    @(negedge clock);
    check("bite_kick_state", 32'(state), 3);
    check("bite_kick_rem", 32'(remainingMs), 0);
    chipStatus.clear = 1'b1;
    @(negedge clock);
    check("clear_state", 32'(state), 0);
    check("clear_bite", 32'(bite), 0);
    check("clear_cnt", 32'(biteCount), 1);
    check("clear_rem", 32'(remainingMs), 5);
    chipStatus.clear = 1'b0;
    @(negedge clock);
    check("rearm_state", 32'(state), 1);
    for (int i = 0; i < 5; i++) do_tick();
    check("bite2_state", 32'(state), 3);
    check("bite2_cnt", 32'(biteCount), 2);

    // Kicking every 3 ticks keeps the watchdog alive
    chipStatus.clear = 1'b1;
    @(negedge clock);
    chipStatus.clear = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      repeat (3) do_tick();
      check("kick_loop_rem", 32'(remainingMs), 2);
      check("kick_loop_st", 32'({state, bite}), {2'd2, 1'b0});
      kick = 1'b1;
      @(negedge clock);
      kick = 1'b0;
      check("kick_loop_reload", 32'({state, warn, remainingMs}), {2'd1, 1'b0, 16'd5});
    end

    // Kick in the same cycle as the strobe with one ms left
    repeat (4) do_tick();
    check("coll_pre_rem", 32'(remainingMs), 1);
    chipStatus.tick1ms = 1'b1;
    @(negedge clock);
    kick = 1'b1;
    @(negedge clock);
    kick = 1'b0;
    check("coll_state", 32'(state), 1);
    check("coll_rem", 32'(remainingMs), 5);
    check("coll_bite", 32'(bite), 0);
    repeat (TickWidth - 2) @(negedge clock);
    chipStatus.tick1ms = 1'b0;
    repeat (TickPeriod - TickWidth) @(negedge clock);
    check("coll_after_rem", 32'(remainingMs), 5);

    // Halt freezes the countdown
    do_tick();
    check("halt_pre_rem", 32'(remainingMs), 4);
    chipStatus.halt = 1'b1;
    repeat (3) do_tick();
    check("halt_rem", 32'(remainingMs), 4);
    check("halt_state", 32'(state), 1);
    chipStatus.halt = 1'b0;
    do_tick();
    check("unhalt_rem1", 32'(remainingMs), 3);
    do_tick();
    check("unhalt_rem2", 32'(remainingMs), 2);
    check("unhalt_warn", 32'(warn), 1);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", 32'({state, warn, remainingMs}), 0);
    @(negedge clock);
    cfgTimeoutMs = 16'd0;
    reset        = 1'b1;
    @(negedge clock);
    check("zero_to_rem", 32'(remainingMs), 1);
    do_tick();
    check("zero_to_bite", 32'({state, bite}), {2'd3, 1'b1});
    check("zero_to_cnt", 32'(biteCount), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
